// File: rtl/mix_columns_seq_if.sv
// Handshake bundle between ShiftRows, the MixColumns stage and AddRoundKey.
// The master side drives the input beat and consumes the result; the slave
// side is the MixColumns block itself.
interface mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         last_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;

    modport master (
        output in_valid, data_in, last_round, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, data_in, last_round, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: one 32-bit column per clock through a single shared
// column unit, four columns per state. A last-round block skips the arithmetic
// and is presented unchanged on the cycle after it is accepted.
module mix_columns_seq (
    input  logic                 clk,
    input  logic                 rst_n,
    mix_columns_seq_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [1:0]   col_cnt;
    logic [127:0] st;
    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic         in_xfer;
    logic         out_xfer;

    // GF(2^8) multiply by 2 with reduction by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // One MixColumns column; the top byte is row 0.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

    // Handshake qualifiers. in_ready in DONE depends on out_ready so a new
    // block can be loaded on the same edge the finished one leaves.
    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign in_xfer       = bus.in_valid && bus.in_ready;
    assign out_xfer      = (state == DONE) && bus.out_ready;

    // Status and result are straight decodes of registered state.
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.data_out  = st;

    // Select the column currently being transformed; column 0 is the top word.
    always_comb begin
        // NOTE: a default before the case keeps this purely combinational; a
        // path that leaves col_in unassigned would infer a latch.
        col_in = st[127:96];
        case (col_cnt)
            2'd0: col_in = st[127:96];
            2'd1: col_in = st[95:64];
            2'd2: col_in = st[63:32];
            2'd3: col_in = st[31:0];
            default: col_in = st[127:96];
        endcase
    end

    assign col_out = mix_col(col_in);

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_xfer) state_nxt = bus.last_round ? DONE : CALC;
            end
            CALC: begin
                if (col_cnt == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                if (in_xfer)       state_nxt = bus.last_round ? DONE : CALC;
                else if (out_xfer) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Column counter: cleared on load, walks 0..3 during CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= 2'd0;
        end else if (in_xfer) begin
            col_cnt <= 2'd0;
        end else if (state == CALC) begin
            col_cnt <= col_cnt + 2'd1;
        end
    end

    // State register: load on accept, rewrite one column per CALC cycle,
    // otherwise hold so data_out is stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: st is reset because it drives data_out directly and must read
        // zero after reset; an aborted block never leaks out.
        if (!rst_n) begin
            st <= 128'h0;
        end else if (in_xfer) begin
            st <= bus.data_in;
        end else if (state == CALC) begin
            case (col_cnt)
                2'd0: st[127:96] <= col_out;
                2'd1: st[95:64]  <= col_out;
                2'd2: st[63:32]  <= col_out;
                2'd3: st[31:0]   <= col_out;
                default: st <= st;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq with a matrix-based GF(2^8) model.
module tb_mix_columns_seq;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    mix_columns_seq_if bus ();

    mix_columns_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Whole-state reference: circulant matrix applied to each column.
    function automatic logic [127:0] model(input logic [127:0] s, input logic lr);
        logic [7:0]   m [4][4];
        logic [7:0]   a [4];
        logic [7:0]   r;
        logic [127:0] res;
        m[0] = '{8'd2, 8'd3, 8'd1, 8'd1};
        m[1] = '{8'd1, 8'd2, 8'd3, 8'd1};
        m[2] = '{8'd1, 8'd1, 8'd2, 8'd3};
        m[3] = '{8'd3, 8'd1, 8'd1, 8'd2};
        if (lr) return s;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) a[row] = s[127 - 32*c - 8*row -: 8];
            for (int row = 0; row < 4; row++) begin
                r = 8'h00;
                for (int k = 0; k < 4; k++) r = r ^ gmul(m[row][k], a[k]);
                res[127 - 32*c - 8*row -: 8] = r;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present one block at a negedge; transfer happens on the following posedge.
    task automatic drive_accept(input logic [127:0] d, input logic lr, input string nm);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.data_in    = d;
        bus.last_round = lr;
        compared++;
        if (bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s in_ready: got %b want 1", nm, bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.data_in  = rand128();
    endtask

    // Called at the negedge after the accept edge; counts edges until out_valid.
    task automatic wait_out(input int want_lat, input string nm);
        int cyc;
        bit calc_ready_bad;
        cyc = 0;
        calc_ready_bad = 0;
        while (bus.out_valid !== 1'b1 && cyc < 20) begin
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) calc_ready_bad = 1;
            @(negedge clk);
            cyc++;
        end
        compared++;
        if (cyc !== want_lat) begin
            mismatched++;
            $display("FAIL %s latency: got %0d want %0d", nm, cyc, want_lat);
        end
        compared++;
        if (calc_ready_bad) begin
            mismatched++;
            $display("FAIL %s in_ready/busy during CALC: got ready high or not busy want ready=0 busy=1", nm);
        end
    endtask

    task automatic check_data(input logic [127:0] want, input string nm);
        compared++;
        if (bus.data_out !== want) begin
            mismatched++;
            $display("FAIL %s data_out: got %h want %h", nm, bus.data_out, want);
        end
    endtask

    // Take the result: out_ready for one edge.
    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_block(input logic [127:0] d, input logic lr, input logic [127:0] want,
                             input string nm);
        drive_accept(d, lr, nm);
        wait_out(lr ? 0 : 4, nm);
        check_data(want, nm);
        drain();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.data_in = '0;
        bus.last_round = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== 128'h0) begin
            mismatched++;
            $display("FAIL reset outputs: got ov=%b busy=%b data=%h want 0/0/0",
                     bus.out_valid, bus.busy, bus.data_out);
        end
        rst_n = 1'b1;
        #1;
        compared++;
        if (bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_fips();
        logic [127:0] d;
        d = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        run_block(d, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c, "fips_round1");
    endtask

    task automatic test_bypass();
        logic [127:0] d;
        d = 128'h00112233445566778899aabbccddeeff;
        run_block(d, 1'b1, d, "bypass");
    endtask

    task automatic test_vectors();
        run_block({4{32'h01010101}}, 1'b0, {4{32'h01010101}}, "vec_01");
        run_block({4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}}, "vec_c6");
        run_block({32'hd4d4d4d5, 32'h2d26314c, 32'h01010101, 32'hc6c6c6c6}, 1'b0,
                  {32'hd5d5d7d6, 32'h4d7ebdf8, 32'h01010101, 32'hc6c6c6c6}, "vec_mix");
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b, held;
        bit bad;
        a = rand128();
        b = rand128();
        drive_accept(a, 1'b0, "bp_first");
        wait_out(4, "bp_first");
        check_data(model(a, 1'b0), "bp_first");
        held = bus.data_out;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.data_out !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad = 1;
        end
        compared++;
        if (bad) begin
            mismatched++;
            $display("FAIL backpressure hold: got change in data/out_valid/in_ready want stable, ready=0");
        end
        // Release and present the next block together.
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.data_in    = b;
        bus.last_round = 1'b0;
        #1;
        compared++;
        if (bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bp same-edge in_ready: got %b want 1", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        wait_out(4, "bp_second");
        check_data(model(b, 1'b0), "bp_second");
        drain();
    endtask

    task automatic test_reset_mid_calc();
        logic [127:0] a, f;
        a = rand128();
        f = rand128();
        drive_accept(a, 1'b0, "rst_mid");   // now after E0
        @(negedge clk);                     // after E1
        @(negedge clk);                     // after E2
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.out_valid !== 1'b0 || bus.data_out !== 128'h0 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid outputs: got ov=%b data=%h busy=%b want 0/0/0",
                     bus.out_valid, bus.data_out, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compared++;
        if (bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mid in_ready: got %b want 1", bus.in_ready);
        end
        run_block(f, 1'b0, model(f, 1'b0), "rst_mid_fresh");
    endtask

    task automatic test_busy_ignore();
        logic [127:0] a;
        bit acc;
        a = rand128();
        drive_accept(a, 1'b0, "busy_ign");  // after E0
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid   = $urandom_range(0, 1);
            bus.data_in    = rand128();
            bus.last_round = $urandom_range(0, 1);
            #1;
            if (bus.in_ready !== 1'b0) acc = 1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        compared++;
        if (acc) begin
            mismatched++;
            $display("FAIL busy_ign in_ready: got 1 while busy want 0");
        end
        compared++;
        if (bus.out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_ign out_valid: got %b want 1", bus.out_valid);
        end
        check_data(model(a, 1'b0), "busy_ign");
        drain();
    endtask

    // Streaming with out_ready tied high; scoreboard queue and throughput check.
    task automatic test_back_to_back(input bit all_normal, input int n, input string nm);
        logic [127:0] q_exp [$];
        logic [127:0] d;
        logic         lr;
        int idx, got, cyc, first_acc, last_acc;
        idx = 0;
        got = 0;
        cyc = 0;
        first_acc = -1;
        last_acc = -1;
        bus.out_ready = 1'b1;
        d  = rand128();
        lr = all_normal ? 1'b0 : 1'($urandom_range(0, 1));
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid === 1'b1) begin
                compared++;
                if (q_exp.size() == 0) begin
                    mismatched++;
                    $display("FAIL %s unexpected output: got %h want none", nm, bus.data_out);
                end else if (bus.data_out !== q_exp[0]) begin
                    mismatched++;
                    $display("FAIL %s stream data: got %h want %h", nm, bus.data_out, q_exp[0]);
                end
                if (q_exp.size() != 0) void'(q_exp.pop_front());
                got++;
            end
            if (idx < n) begin
                bus.in_valid   = 1'b1;
                bus.data_in    = d;
                bus.last_round = lr;
                #1;
                if (bus.in_ready === 1'b1) begin
                    q_exp.push_back(model(d, lr));
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                    idx++;
                    d  = rand128();
                    lr = all_normal ? 1'b0 : 1'($urandom_range(0, 1));
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        compared++;
        if (got !== n) begin
            mismatched++;
            $display("FAIL %s output count: got %0d want %0d", nm, got, n);
        end
        if (all_normal) begin
            compared++;
            if (last_acc - first_acc !== 5 * (n - 1)) begin
                mismatched++;
                $display("FAIL %s throughput span: got %0d want %0d", nm,
                         last_acc - first_acc, 5 * (n - 1));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random_single();
        logic [127:0] d;
        logic lr;
        for (int i = 0; i < 6; i++) begin
            d  = rand128();
            lr = 1'($urandom_range(0, 1));
            run_block(d, lr, model(d, lr), "random_single");
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_fips();
        test_bypass();
        test_vectors();
        test_backpressure();
        test_reset_mid_calc();
        test_busy_ignore();
        test_random_single();
        test_back_to_back(1'b1, 8, "b2b_normal");
        test_back_to_back(1'b0, 12, "b2b_mixed");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Absolute time bound so a stuck DUT still ends the run.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Iterative AES MixColumns stage that sits directly downstream of the ShiftRows stage and consumes its 128-bit output.
- Accepts one state per handshake and transforms one 32-bit column per clock, four columns in total.
- Presents the result to the AddRoundKey stage through a valid/ready handshake.
- A per-block bypass input passes the state through unchanged, because the final AES round omits MixColumns.

Parameters:
- None. Width is fixed at 128-bit state and 4 columns.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  data_in and last_round are valid.
- in_ready  output  1  block can accept a state this cycle.
- data_in  input  128  state from ShiftRows. Column c = data_in[127-32c -: 32]. The top byte of each column is row 0.
- last_round  input  1  sampled with data_in; 1 = bypass MixColumns.
- out_valid  output  1  data_out holds a finished state.
- out_ready  input  1  downstream accepts data_out this cycle.
- data_out  output  128  transformed state, same byte layout as data_in.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, col_cnt = 0, data_out = 128'h0.
  - out_valid = 0, busy = 0, in_ready = 1 (in_ready as soon as rst_n deasserts).
  - Asserting reset mid-operation discards the in-flight block; no partial output is ever presented.
- Handshakes:
  - Input transfer occurs on a rising edge where in_valid & in_ready.
  - Output transfer occurs on a rising edge where out_valid & out_ready.
  - in_ready = (state==IDLE) | (state==DONE & out_ready). This combinational path is the only one from out_ready.
- State register: a single 128-bit register st, driven onto data_out.
- FSM:
  - IDLE: on input transfer, st <= data_in, col_cnt <= 0.
    - If last_round = 1, go to DONE.
    - If last_round = 0, go to CALC.
  - CALC: each edge replaces column col_cnt of st with MixColumns(column) and increments col_cnt.
    - On the edge where col_cnt==3: col_cnt <= 0, go to DONE.
    - in_valid is ignored in CALC.
  - DONE: out_valid = 1, and st is held stable until transfer.
    - On output transfer without a simultaneous input transfer, go to IDLE.
    - On output transfer with a simultaneous input transfer (in_valid high), load the new block exactly as from IDLE. No bubble.
    - While out_ready = 0, data_out and out_valid must not change.
- Latency, with E0 = input transfer edge:
  - Normal block: CALC edges are E1..E4, and out_valid is high from the cycle after E4 (4-cycle latency).
  - Bypass block: out_valid is high from the cycle after E0.
- Throughput: one normal block per 5 cycles with back-to-back handshakes and out_ready tied high.
- Column arithmetic, for bytes a0..a3 (row 0..3):
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00); 3·b = xtime(b)^b.
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
  - The datapath is one shared 32-bit column unit, muxed by col_cnt. A single column's logic is used, not four copies.
- out_valid and busy are registered and decoded from the FSM state. out_valid is never high in IDLE or CALC.

Test Plan:
- FIPS-197 Appendix B round 1:
  - Stimulus: data_in = d4bf5d30e0b452aeb84111f11e2798e5, last_round = 0.
  - Required: data_out = 046681e5e0cb199a48f8d37a2806264c; out_valid rises exactly 4 cycles after acceptance; in_ready is low during CALC.
- Bypass:
  - Stimulus: data_in = 00112233445566778899aabbccddeeff, last_round = 1.
  - Required: identical data_out with out_valid high 1 cycle after acceptance.
- Fixed-point and xtime carry:
  - Stimulus: columns 01010101, c6c6c6c6, d4d4d4d5, 2d26314c.
  - Required: 01010101, c6c6c6c6, d5d5d7d6, 4d7ebdf8.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles in DONE.
  - Required: data_out and out_valid are stable and in_ready = 0.
  - Then raise out_ready together with in_valid. Required: the second block is accepted on the same edge, and its result appears 4 cycles later.
- Reset mid-CALC:
  - Stimulus: drop rst_n after 2 CALC edges.
  - Required: out_valid = 0 and data_out = 0 immediately; in_ready = 1 after release.
  - A fresh block then produces a correct result.
- Input ignored while busy:
  - Stimulus: toggle in_valid with random data during CALC.
  - Required: no acceptance, and the result is unaffected.
